mem_responder: RTL

- Memory-side responder for the CPU's mem_read/mem_write/mem_resp handshake.
- Sits opposite the datapath's load-enabled registers (MAR/MDR), which capture mem_rdata when mem_resp is seen.
- Holds a small internal word-addressed RAM and inserts a programmable number of wait states before each response.
- Serves as the memory model in simulation and as an on-chip scratch memory on the FPGA.

---
 rtl/mem_responder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the mem_read / mem_write / mem_resp
// handshake. A request seen in IDLE is latched, held for a programmable number
// of wait states, then completed with a one-cycle mem_resp pulse. Reads load
// mem_rdata and writes update the enabled bytes of the internal word RAM.
module mem_responder #(
  parameter int width       = 16,
  parameter int addr_width  = 8,
  parameter int wait_cycles = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [15:0]          mem_address,
  input  logic [width-1:0]     mem_wdata,
  input  logic [width/8-1:0]   mem_byte_enable,
  output logic [width-1:0]     mem_rdata,
  output logic                 mem_resp
);

  localparam int nbytes = width / 8;
  localparam int depth  = 1 << addr_width;
  // The counter only ever holds values up to wait_cycles-1.
  localparam int cnt_w  = (wait_cycles > 1) ? $clog2(wait_cycles) : 1;
  localparam logic [cnt_w-1:0] cnt_init =
    cnt_w'((wait_cycles > 0) ? (wait_cycles - 1) : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;
  logic [cnt_w-1:0] count, count_next;

  // Handshake decode produced by the next-state logic.
  logic accept;
  logic enter_resp;

  // Latched copy of the transaction taken in IDLE.
  logic                  lat_read;
  logic                  lat_write;
  logic [addr_width-1:0] lat_index;
  logic [width-1:0]      lat_wdata;
  logic [nbytes-1:0]     lat_be;

  // Operation actually performed on the RESP-entry edge.
  logic                  op_read;
  logic                  op_write;
  logic [addr_width-1:0] op_index;
  logic [width-1:0]      op_wdata;
  logic [nbytes-1:0]     op_be;

  // Output-side decode of the RESP-entry action.
  logic                  resp_next;
  logic                  rdata_load;
  logic [nbytes-1:0]     byte_we;

  // Word RAM; powers up cleared in simulation and in the FPGA bitstream.
  logic [width-1:0] ram [depth] = '{default: '0};

  // Only the word-index bits of the address matter; the rest are don't-care.
  logic unused_addr;
  assign unused_addr = ^mem_address;

  // State register: FSM state and wait-state counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, one cycle in RESP.
  always_comb begin
    state_next = state;
    count_next = count;
    accept     = 1'b0;
    enter_resp = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_read || mem_write) begin
          accept = 1'b1;
          if (wait_cycles == 0) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
            count_next = cnt_init;
          end
        end
      end
      WAIT: begin
        if (count != '0) begin
          count_next = count - cnt_w'(1);
        end else begin
          state_next = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic: pick live inputs when completing straight from IDLE
  // (zero wait states), otherwise the latched copy, and decode the action.
  always_comb begin
    if (state == IDLE) begin
      op_read  = mem_read;
      op_write = mem_write && !mem_read;
      op_index = mem_address[addr_width:1];
      op_wdata = mem_wdata;
      op_be    = mem_byte_enable;
    end else begin
      op_read  = lat_read;
      op_write = lat_write;
      op_index = lat_index;
      op_wdata = lat_wdata;
      op_be    = lat_be;
    end
    resp_next  = enter_resp;
    rdata_load = enter_resp && op_read;
    byte_we    = (enter_resp && op_write) ? op_be : '0;
  end

  // Transaction latch: snapshot the request so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_read  <= 1'b0;
      lat_write <= 1'b0;
      lat_index <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else if (accept) begin
      lat_read  <= mem_read;
      lat_write <= mem_write && !mem_read;
      lat_index <= mem_address[addr_width:1];
      lat_wdata <= mem_wdata;
      lat_be    <= mem_byte_enable;
    end
  end

  // Registered outputs: completion pulse and read data holding the last read.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_resp  <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_resp <= resp_next;
      if (rdata_load) begin
        mem_rdata <= ram[op_index];
      end
    end
  end

  // RAM byte writes on the RESP-entry edge; a reset on that edge abandons it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int b = 0; b < nbytes; b++) begin
        if (byte_we[b]) begin
          ram[op_index][8*b +: 8] <= op_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
